// File: rtl/mux2to1_d_if.sv
// Bus bundle for the 2:1 mux: two data inputs, the select line and both outputs.
// The master drives the inputs; the slave (the mux) drives c and c_q.
interface mux2to1_d_if #(
    parameter int width = 64
);
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             sel;
    logic [width-1:0] c;
    logic [width-1:0] c_q;

    modport master (
        output a,
        output b,
        output sel,
        input  c,
        input  c_q
    );

    modport slave (
        input  a,
        input  b,
        input  sel,
        output c,
        output c_q
    );
endinterface

// File: rtl/mux2to1_d.sv
// 2:1 data-routing mux: combinational output c plus a registered copy c_q that
// clears asynchronously on rst. Basic selection primitive for wider mux trees.
module mux2to1_d #(
    parameter int width = 64
) (
    input  logic          clk,
    input  logic          rst,
    mux2to1_d_if.slave    bus
);
    logic [width-1:0] c_next;
    logic [width-1:0] c_q_reg;

    // Per-bit ?: keeps the standard X-merge behaviour when sel is unknown:
    // bits where a and b agree survive, differing bits go to X.
    for (genvar gi = 0; gi < width; gi++) begin : g_bit
        assign c_next[gi] = bus.sel ? bus.b[gi] : bus.a[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q_reg <= '0;
        end else begin
            c_q_reg <= c_next;
        end
    end

    assign bus.c   = c_next;
    assign bus.c_q = c_q_reg;
endmodule

// File: tb/tb_mux2to1_d.sv
// Bench for mux2to1_d at widths 1, 8 and 64: directed table, hand-written
// register/reset sequences, random traffic against a word-level model, walking ones.
module tb_mux2to1_d;
    logic clk;
    logic clk_en;
    logic rst;
    int   n_pass;
    int   n_total;

    mux2to1_d_if #(.width(1))  if1 ();
    mux2to1_d_if #(.width(8))  if8 ();
    mux2to1_d_if #(.width(64)) if64 ();

    mux2to1_d #(.width(1))  u_w1  (.clk(clk), .rst(rst), .bus(if1));
    mux2to1_d #(.width(8))  u_w8  (.clk(clk), .rst(rst), .bus(if8));
    mux2to1_d #(.width(64)) u_w64 (.clk(clk), .rst(rst), .bus(if64));

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sel;
        logic [63:0] exp_c;
    } vec_t;

    vec_t vecs [13];
    int   ws [3] = '{1, 8, 64};

    function automatic logic [63:0] mask_w(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: pick the whole word, then keep the low w bits.
    function automatic logic [63:0] ref_mux(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic s);
        return (s ? b : a) & mask_w(w);
    endfunction

    function automatic logic [63:0] get_c(input int k);
        case (k)
            0:       return {63'd0, if1.c};
            1:       return {56'd0, if8.c};
            default: return if64.c;
        endcase
    endfunction

    function automatic logic [63:0] get_cq(input int k);
        case (k)
            0:       return {63'd0, if1.c_q};
            1:       return {56'd0, if8.c_q};
            default: return if64.c_q;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic set_in(input logic [63:0] a, input logic [63:0] b, input logic s);
        if64.a = a;      if64.b = b;      if64.sel = s;
        if8.a  = a[7:0]; if8.b  = b[7:0]; if8.sel  = s;
        if1.a  = a[0];   if1.b  = b[0];   if1.sel  = s;
    endtask

    task automatic check_c_all(input string name, input logic [63:0] a,
                               input logic [63:0] b, input logic s);
        for (int k = 0; k < 3; k++)
            check($sformatf("%s_c_w%0d", name, ws[k]), get_c(k), ref_mux(ws[k], a, b, s));
    endtask

    task automatic check_cq_all(input string name, input logic [63:0] exp64);
        for (int k = 0; k < 3; k++)
            check($sformatf("%s_cq_w%0d", name, ws[k]), get_cq(k), exp64 & mask_w(ws[k]));
    endtask

    initial begin
        logic [63:0] ra, rb, pa, pb;
        logic        rs, rr, ps;

        n_pass  = 0;
        n_total = 0;
        clk_en  = 1'b0;
        rst     = 1'b0;
        set_in(64'd0, 64'd0, 1'b0);

        vecs[0]  = '{64'hA000_0000_0000_0000, 64'hB000_0000_0000_0000, 1'b0, 64'hA000_0000_0000_0000};
        vecs[1]  = '{64'hB000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b0, 64'hB000_0000_0000_0000};
        vecs[2]  = '{64'hC000_0000_0000_0000, 64'hD000_0000_0000_0000, 1'b0, 64'hC000_0000_0000_0000};
        vecs[3]  = '{64'hD000_0000_0000_0000, 64'hE000_0000_0000_0000, 1'b0, 64'hD000_0000_0000_0000};
        vecs[4]  = '{64'hE000_0000_0000_0000, 64'hF000_0000_0000_0000, 1'b0, 64'hE000_0000_0000_0000};
        vecs[5]  = '{64'hA000_0000_0000_0000, 64'hB000_0000_0000_0000, 1'b1, 64'hB000_0000_0000_0000};
        vecs[6]  = '{64'hB000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b1, 64'hC000_0000_0000_0000};
        vecs[7]  = '{64'hC000_0000_0000_0000, 64'hD000_0000_0000_0000, 1'b1, 64'hD000_0000_0000_0000};
        vecs[8]  = '{64'hD000_0000_0000_0000, 64'hE000_0000_0000_0000, 1'b1, 64'hE000_0000_0000_0000};
        vecs[9]  = '{64'hE000_0000_0000_0000, 64'hF000_0000_0000_0000, 1'b1, 64'hF000_0000_0000_0000};
        vecs[10] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[11] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h5555_5555_5555_5555};
        vecs[12] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA};

        // Combinational table with the clock stopped.
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].a, vecs[i].b, vecs[i].sel);
            #1;
            $display("vec %0d: a=%h b=%h sel=%b c=%h", i, vecs[i].a, vecs[i].b, vecs[i].sel, if64.c);
            check($sformatf("vec%0d_c_w64", i), if64.c, vecs[i].exp_c);
            check($sformatf("vec%0d_c_w8", i), {56'd0, if8.c}, ref_mux(8, vecs[i].a, vecs[i].b, vecs[i].sel));
            check($sformatf("vec%0d_c_w1", i), {63'd0, if1.c}, ref_mux(1, vecs[i].a, vecs[i].b, vecs[i].sel));
            #29;
        end

        // Reset with no clock edge.
        rst = 1'b1;
        #1;
        $display("seq: rst asserted, clock stopped");
        check_cq_all("rst_noclk", 64'd0);
        check_c_all("rst_noclk", vecs[12].a, vecs[12].b, 1'b0);

        // Release, select b; capture only on the next edge.
        rst = 1'b0;
        set_in(64'h0, 64'hB000_0000_0000_0001, 1'b1);
        #1;
        $display("seq: rst released, sel=1, before edge");
        check_cq_all("pre_edge", 64'd0);
        clk_en = 1'b1;
        @(posedge clk); #1;
        $display("seq: first edge after release c_q=%h", if64.c_q);
        check_cq_all("first_edge", 64'hB000_0000_0000_0001);

        // Mid-cycle select change: c immediate, c_q waits.
        set_in(64'h1234_5678_9ABC_DEF1, 64'hB000_0000_0000_0001, 1'b0);
        #1;
        $display("seq: mid-cycle sel=0 c=%h c_q=%h", if64.c, if64.c_q);
        check_c_all("mid_sel", 64'h1234_5678_9ABC_DEF1, 64'hB000_0000_0000_0001, 1'b0);
        check_cq_all("mid_sel_hold", 64'hB000_0000_0000_0001);
        @(posedge clk); #1;
        $display("seq: next edge c_q=%h", if64.c_q);
        check_cq_all("mid_sel_edge", 64'h1234_5678_9ABC_DEF1);

        // Asynchronous reset between edges, held over an edge.
        #1;
        rst = 1'b1;
        #1;
        $display("seq: rst mid-cycle c_q=%h c=%h", if64.c_q, if64.c);
        check_cq_all("async_rst", 64'd0);
        check_c_all("async_rst", 64'h1234_5678_9ABC_DEF1, 64'hB000_0000_0000_0001, 1'b0);
        @(posedge clk); #1;
        check_cq_all("rst_held", 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("seq: capture after rst release c_q=%h", if64.c_q);
        check_cq_all("post_rst", 64'h1234_5678_9ABC_DEF1);

        // Random traffic with occasional reset pulses.
        pa = 64'd0; pb = 64'd0; ps = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            rr = (i == 0) || ($urandom_range(0, 15) == 0);
            set_in(ra, rb, rs);
            rst = rr;
            #1;
            $display("rnd %0d: a=%h b=%h sel=%b rst=%b", i, ra, rb, rs, rr);
            check_c_all($sformatf("rnd%0d", i), ra, rb, rs);
            check_cq_all($sformatf("rnd%0d_pre", i), rr ? 64'd0 : (ps ? pb : pa));
            @(posedge clk); #1;
            check_cq_all($sformatf("rnd%0d_post", i), rr ? 64'd0 : (rs ? rb : ra));
            // Track what the register should now hold for the next pre-edge check.
            if (rr) begin
                pa = 64'd0; pb = 64'd0; ps = 1'b0;
            end else begin
                pa = ra; pb = rb; ps = rs;
            end
        end
        @(negedge clk);
        rst = 1'b0;

        // Walking ones on each width, both select values.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ws[k]; i++) begin
                for (int s = 0; s < 2; s++) begin
                    ra = 64'd1 << i;
                    rb = ~ra;
                    set_in(ra, rb, 1'(s));
                    #1;
                    $display("walk w%0d bit %0d sel=%0d c=%h", ws[k], i, s, get_c(k));
                    check($sformatf("walk_w%0d_b%0d_s%0d", ws[k], i, s), get_c(k),
                          ref_mux(ws[k], ra, rb, 1'(s)));
                    #4;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mux2to1_d.md
Name:
mux2to1_d

Overview:
- Parameterised 2:1 data-routing multiplexer, data-flow style, selecting one of two `width`-bit buses.
- Primary output `c` is purely combinational.
- A registered copy `c_q` is provided for pipelined consumers; it is clocked by the single system clock with asynchronous active-high reset.
- Sits in the data-routing library as the basic selection primitive for wider mux trees.

Parameters:
- width, 64, bit width of data inputs `a`, `b` and outputs `c`, `c_q`; legal range ≥ 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- a  input  width  data input selected when sel = 0.
- b  input  width  data input selected when sel = 1.
- sel  input  1  select line.
- c  output  width  combinational mux output.
- c_q  output  width  registered mux output.

Behaviour:
- Interface: one clock (`clk`); reset (`rst`) is asynchronous and active-high.
- Combinational path:
  - c = a when sel = 0; c = b when sel = 1.
  - No clock involvement and zero latency: c follows any change on a, b or sel within the same delta.
  - c is independent of rst; c continues to follow inputs while rst is asserted.
- X/Z on sel:
  - Bits where a and b agree pass through unchanged.
  - Bits where they differ resolve to X, per the standard `?:` operator semantics.
- Full-width routing: all `width` bits pass unmodified. No truncation, extension or bit reordering; MSB of the selected input appears at c[width-1].
- Registered path:
  - On every rising edge of clk with rst low, c_q ← (sel ? b : a). Latency is 1 cycle relative to c.
  - rst high forces c_q to all-zeros immediately, without waiting for a clock edge.
  - c_q holds zero for as long as rst is high.
  - On the first rising edge after rst deasserts, c_q captures the current mux result.
- Reset asserted mid-operation: c_q clears asynchronously; c keeps tracking the inputs.
- Simultaneous input change and clock edge: c_q captures the values present before the edge, using standard non-blocking semantics.
- No state other than the c_q register; no handshake; no enable.
- Fully synthesizable; no latches are inferred on the combinational path.

Test Plan:
- sel = 0, a = 0xA000_0000_0000_0000, b = 0xB000_0000_0000_0000 -> c = 0xA000_0000_0000_0000 immediately. Repeat with pairs (B,C), (C,D), (D,E), (E,F) in the top nibble; c must equal a each time. Hold each vector 30 time units.
- sel = 1 with the same five pairs -> c = b each time (0xB…, 0xC…, 0xD…, 0xE…, 0xF…, lower 60 bits zero).
- Toggle sel 0→1→0 with a = 0xAAAA_AAAA_AAAA_AAAA, b = 0x5555_5555_5555_5555 -> c alternates a, b, a with no clock applied. Confirms all 64 bits route and the path is combinational.
- Registered path:
  - Assert rst: c_q = 0 without any clock edge.
  - Release rst, set sel = 1, b = 0xB000_0000_0000_0000: c_q = 0 before the next edge, and 0xB000_0000_0000_0000 after it.
  - Change sel to 0 mid-cycle: c changes at once; c_q changes only at the next edge.
- Assert rst between clock edges while c_q is non-zero -> c_q goes to 0 asynchronously; c still equals the selected input.
- Parameter sweep width = 1, 8, 64: walking-one patterns on a and b with both sel values -> c matches the selected input bit-for-bit at every width.
